// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM encodings, flush depth and saturation limits for mac_stream.
`default_nettype none

package mac_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACC   = 2'd1;
  localparam state_t ST_FLUSH = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  localparam int FLUSH_CYCLES = 2;

  // Limits are returned wide; callers truncate to their accumulator width.
  function automatic logic [127:0] sat_max_f(input int w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] sat_min_f(input int w);
    return 128'd1 << (w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_acc_stage.sv
// mac_acc_stage: sign-extend product, accumulate, optional saturation (MAC_SAT_EN) and sticky ovf.
`default_nettype none

module mac_acc_stage
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       add_en,
  input  logic signed [2*DATA_W-1:0] prod,
  output logic signed [ACC_W-1:0]    acc,
  output logic                       ovf
);

  logic signed [ACC_W-1:0] prod_ext;
  assign prod_ext = ACC_W'(prod);

`ifdef MAC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max_f(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min_f(ACC_W));

  logic [ACC_W:0]          sum;
  logic                    sat;
  logic signed [ACC_W-1:0] acc_next;

  // One guard bit: the top two bits disagree exactly when the add left the range.
  assign sum = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  assign sat = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (sat) acc_next = sum[ACC_W] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (add_en) begin
      acc <= acc_next;
      if (sat) ovf <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + prod_ext;
    end
  end

  assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/mac_stream.sv
// mac_stream: framed, handshaked signed multiply-accumulate; MAC_SAT_EN selects saturating accumulation.
`default_nettype none

module mac_stream
  import mac_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 18,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic [LEN_W-1:0]         len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out,
  output logic                     ovf
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
    $error("mac_stream: ACC_W must be >= 2*DATA_W");
  end

  state_t                     state;
  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           count;
  logic [FC_W-1:0]            flush_cnt;
  logic signed [2*DATA_W-1:0] prod;
  logic                       prod_vld;
  logic                       in_xfer;
  logic                       out_xfer;
  logic                       frame_start;
  logic [LEN_W-1:0]           len_eff;

  assign in_ready    = rst_n && (state == ST_IDLE || state == ST_ACC);
  assign in_xfer     = in_valid && in_ready;
  assign out_valid   = (state == ST_HOLD);
  assign out_xfer    = out_valid && out_ready;
  assign frame_start = in_xfer && (state == ST_IDLE);
  assign len_eff     = (len == '0) ? LEN_W'(1) : len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      count     <= '0;
      flush_cnt <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
    end else begin
      prod_vld <= in_xfer;
      if (in_xfer) prod <= (2*DATA_W)'(a) * (2*DATA_W)'(b);

      case (state)
        ST_IDLE: begin
          if (in_xfer) begin
            len_q     <= len_eff;
            count     <= LEN_W'(1);
            flush_cnt <= '0;
            state     <= (len_eff == LEN_W'(1)) ? ST_FLUSH : ST_ACC;
          end
        end
        ST_ACC: begin
          if (in_xfer) begin
            count <= count + LEN_W'(1);
            if (count + LEN_W'(1) == len_q) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Lets the last product pass both pipeline stages before presenting it.
          if (flush_cnt == FC_W'(FLUSH_CYCLES - 1)) state <= ST_HOLD;
          else flush_cnt <= flush_cnt + FC_W'(1);
        end
        ST_HOLD: begin
          if (out_xfer) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mac_acc_stage #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (frame_start),
    .add_en (prod_vld),
    .prod   (prod),
    .acc    (out),
    .ovf    (ovf)
  );

endmodule

`default_nettype wire

// File: tb/tb_mac_stream.sv
// tb_mac_stream: directed frames with a queue-based scoreboard checking every output transfer.
`default_nettype none

module tb_mac_stream;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 18;
  localparam int LEN_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a = '0;
  logic signed [DATA_W-1:0] b = '0;
  logic [LEN_W-1:0]         len = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [ACC_W-1:0]  out;
  logic                     ovf;

  mac_stream #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;
  int last_acc = 0;
  int rise_cycle = -1;
  logic prev_ov = 1'b0;
  logic [ACC_W:0] exp_q[$];

  always @(posedge clk) cycle++;

  // Monitor: pops one expected {ovf,out} per output transfer.
  always @(negedge clk) begin
    logic [ACC_W:0] e;
    if (out_valid && !prev_ov) rise_cycle = cycle;
    prev_ov = out_valid;
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result got out=0x%05h ovf=%0b, none expected", out, ovf);
      end else begin
        e = exp_q.pop_front();
        if ({ovf, out} !== e) begin
          n_err++;
          $display("FAIL result got out=0x%05h ovf=%0b expected out=0x%05h ovf=%0b",
                   out, ovf, e[ACC_W-1:0], e[ACC_W]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [ACC_W-1:0] val, input logic o);
    exp_q.push_back({o, val});
  endtask

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input int av, input int bv, input int lv);
    int t = 0;
    in_valid = 1'b1;
    a = DATA_W'(av);
    b = DATA_W'(bv);
    len = LEN_W'(lv);
    @(negedge clk);
    while (!in_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout got in_ready=0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_acc = cycle;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int t;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic frame: 1*5+2*6+3*7+4*8 = 70
    expect_result(18'h00046, 1'b0);
    send(1, 5, 4);
    send(2, 6, 4);
    send(3, 7, 4);
    send(4, 8, 4);
    t = last_acc;
    wait_drain();
    check("basic_latency", 32'(rise_cycle - t), 32'd2);
    @(negedge clk);
    check("basic_one_cycle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Signed extremes, len=1 and len=0
    expect_result(18'h3C080, 1'b0);
    send(-128, 127, 1);
    wait_drain();
    expect_result(18'h3C080, 1'b0);
    send(-128, 127, 0);
    wait_drain();

    // 255 * 16384 overflows an 18-bit accumulator
`ifdef MAC_SAT_EN
    expect_result(18'h1FFFF, 1'b1);
`else
    expect_result(18'h3C000, 1'b0);
`endif
    for (int i = 0; i < 255; i++) send(-128, -128, 255);
    wait_drain();

    // Backpressure
    out_ready = 1'b0;
    expect_result(18'd200, 1'b0);
    send(10, 10, 2);
    send(10, 10, 2);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      t++;
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out", 32'(out), 32'd200);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Bubbles: in_valid 1,0,0,1,0,1
    expect_result(18'd12, 1'b0);
    send(2, 2, 3);
    idle(2);
    send(2, 2, 3);
    idle(1);
    send(2, 2, 3);
    t = last_acc;
    wait_drain();
    check("bubble_latency", 32'(rise_cycle - t), 32'd2);

    // Reset mid-frame: partial sum must vanish
    send(1, 1, 4);
    send(1, 1, 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    expect_result(18'd18, 1'b0);
    send(3, 3, 2);
    send(3, 3, 2);
    wait_drain();

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_stream.md
Name: mac_stream

Overview:
- Parametrised, handshaked signed multiply-accumulate engine; next generation of the free-running `mac` block (18-bit `out`).
- Accepts a stream of (a, b) operand pairs and sums `len` products per frame.
- Emits one accumulated result per frame on a valid/ready output.
- Sits between an operand source (e.g. FIR tap/coefficient sequencer) and a result consumer.

Parameters:
- DATA_W, 8: width of signed operands `a` and `b`.
- ACC_W, 18: accumulator/result width; must be >= 2*DATA_W, else elaboration error.
- LEN_W, 8: width of the frame-length input `len`.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  DATA_W  signed operand.
- b  in  DATA_W  signed operand.
- len  in  LEN_W  products per frame; sampled on the first accepted pair of a frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out  out  ACC_W  signed accumulated result.
- ovf  out  1  overflow flag for current result (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=0 during reset then 1 in IDLE, out_valid=0, out=0, ovf=0, accumulator=0, count=0.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. in_valid gaps are allowed anywhere in a frame.
- FSM:
  - IDLE: in_ready=1. First transfer latches len (len=0 treated as 1), clears accumulator, goes to ACC; if latched len is 1, goes straight to FLUSH.
  - ACC: in_ready=1. Counts transfers; the transfer that makes count equal latched len goes to FLUSH.
  - FLUSH: in_ready=0, exactly 2 cycles, draining product and accumulate stages, then goes to HOLD.
  - HOLD: out_valid=1; out and ovf held stable until output transfer, then goes to IDLE and out_valid drops on the next edge. in_ready=0 in HOLD.
- Pipeline:
  - Stage 1 registers the signed product a*b (2*DATA_W bits).
  - Stage 2 sign-extends the product to ACC_W and adds it to the accumulator.
- Latency: last pair accepted at edge k; out_valid=1 from edge k+2 onward.
- Arithmetic: two's complement; without the feature, the accumulator wraps modulo 2^ACC_W.
- Reset mid-frame or mid-HOLD: partial sum and pending result discarded, no out_valid; the next frame starts clean.
- out_ready asserted outside HOLD is ignored.

Optional Feature:
- Macro: MAC_SAT_EN.
- Defined:
  - Stage 2 saturates each add to +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)).
  - ovf is set sticky for the frame when any add saturated; cleared at frame start.
- Undefined: accumulator wraps, and ovf is tied to 0.

Decomposition:
- Package mac_pkg:
  - FSM state enum (IDLE, ACC, FLUSH, HOLD).
  - FLUSH_CYCLES=2.
  - Saturation limit constants as functions of ACC_W.
- One sub-module, mac_acc_stage: sign-extend, add, optional saturation, ovf generation.
- Top level holds the FSM, counter and product register.

Test Plan:
- Basic frame: DATA_W=8, ACC_W=18; len=4, a=1,2,3,4, b=5,6,7,8 back-to-back, out_ready=1 -> out=70 (0x00046), out_valid 2 cycles after the 4th accept, one cycle wide.
- Signed extremes: len=1, a=-128, b=127 -> out=0x3C080 (-16256), ovf=0; also send len=0 -> treated as 1, same result.
- Overflow: len=255, a=b=-128 every pair.
  - Without MAC_SAT_EN -> out=0x3C000 (-16384 wrapped), ovf=0.
  - With MAC_SAT_EN -> out=0x1FFFF, ovf=1.
- Backpressure: frame len=2 (a=b=10) with out_ready=0 for 5 cycles.
  - out_valid=1 and out=200 stable for all 5 cycles; in_ready=0 throughout.
  - Transfer when out_ready=1; in_ready=1 on the following cycle.
- Bubbles: len=3, a=b=2 with in_valid toggling 1,0,0,1,0,1 -> out=12, latency measured from the 3rd accept = 2.
- Reset mid-frame: 2 of 4 pairs accepted, rst_n=0 for 1 cycle -> out_valid stays 0. Then len=2, a=b=3 -> out=18 (no residue).
